// File: rtl/rle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rle_sequencer
//  Purpose  : Capture-core controller for the run-length encoder. Latches the
//             RLE configuration, arms the encoder, counts output words after
//             the trigger, forces a final flush so readback ends on a complete
//             value/count pair, and reports capture completion.
//  Options  : RLE_SEQ_TIMEOUT_EN - adds a watchdog that abandons a FLUSH that
//             never sees rle_flushed after FLUSH_TMO cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module rle_sequencer #(
  parameter int CNT_W     = 16,
  parameter int FLUSH_TMO = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_disabledGroups,
  input  logic             cfg_rle_en,
  input  logic             cfg_repeat_mode,
  input  logic [CNT_W-1:0] cfg_readCount,
  input  logic             arm,
  input  logic             abort,
  input  logic             triggered,
  input  logic             rle_validOut,
  input  logic             rle_flushed,
  output logic             rle_enable,
  output logic [1:0]       rle_mode,
  output logic [31:0]      rle_data_mask,
  output logic             rle_repeat_mode,
  output logic             rle_flush,
  output logic             capture_done,
  output logic             cfg_error,
  output logic             flush_timeout
);

  // Reject parameterisations the counters and watchdog cannot represent.
  if (CNT_W < 2 || FLUSH_TMO < 1) begin : g_param_check
    $error("rle_sequencer: CNT_W must be >= 2 and FLUSH_TMO >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   read_count_q;
  logic               rle_en_q;
  logic               rle_enable_q;
  logic [1:0]         rle_mode_q;
  logic [31:0]        data_mask_q;
  logic               repeat_q;
  logic               flush_q;
  logic               done_q;
  logic               cfg_error_q;

  logic [2:0]         k_d;
  logic [1:0]         mode_d;
  logic [31:0]        mask_d;
  logic               cfg_err_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               flush_hit_d;

`ifdef RLE_SEQ_TIMEOUT_EN
  // Watchdog is at least 8 bits wide, wider if the limit needs it.
  localparam int TMO_W = ($clog2(FLUSH_TMO + 1) > 8) ? $clog2(FLUSH_TMO + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FLUSH_TMO - 1);
  logic [TMO_W-1:0]   tmo_q;
  logic               flush_timeout_q;
  assign flush_timeout = flush_timeout_q;
`else
  assign flush_timeout = 1'b0;
`endif

  // Decode the group-disable field into flag position and byte mask.
  always_comb begin
    k_d    = 3'd0;
    mask_d = 32'h0000_0000;
    for (int n = 0; n < 4; n++) begin
      k_d            = k_d + {2'b00, ~cfg_disabledGroups[n]};
      mask_d[8*n +: 8] = cfg_disabledGroups[n] ? 8'h00 : 8'hFF;
    end
    cfg_err_d = (k_d == 3'd0);
    mode_d    = cfg_err_d ? 2'd3 : 2'(k_d - 3'd1);
    if (cfg_err_d) begin
      mask_d = 32'hFFFF_FFFF;
    end
  end

  // Saturating word count including this cycle's word, and the RLE exit test
  // that keeps two slots free for the trailing value/count pair.
  always_comb begin
    cnt_d       = (rle_validOut && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    flush_hit_d = (read_count_q < CNT_W'(2)) || (cnt_d >= (read_count_q - CNT_W'(2)));
  end

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      read_count_q <= '0;
      rle_en_q     <= 1'b0;
      rle_enable_q <= 1'b0;
      rle_mode_q   <= 2'd3;
      data_mask_q  <= 32'hFFFF_FFFF;
      repeat_q     <= 1'b0;
      flush_q      <= 1'b0;
      done_q       <= 1'b0;
      cfg_error_q  <= 1'b0;
`ifdef RLE_SEQ_TIMEOUT_EN
      tmo_q           <= '0;
      flush_timeout_q <= 1'b0;
`endif
    end else if (abort && (state_q != S_IDLE)) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rle_enable_q <= 1'b0;
      flush_q      <= 1'b0;
      done_q       <= 1'b0;
`ifdef RLE_SEQ_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (arm) begin
            state_q      <= S_ARMED;
            rle_enable_q <= cfg_wr ? cfg_rle_en : rle_en_q;
            cfg_error_q  <= 1'b0;
`ifdef RLE_SEQ_TIMEOUT_EN
            flush_timeout_q <= 1'b0;
`endif
          end
          // A configuration error reported in the arming cycle must survive.
          if (cfg_wr) begin
            rle_en_q     <= cfg_rle_en;
            read_count_q <= cfg_readCount;
            rle_mode_q   <= mode_d;
            data_mask_q  <= mask_d;
            repeat_q     <= cfg_repeat_mode;
            if (cfg_err_d) begin
              cfg_error_q <= 1'b1;
            end
          end
        end

        S_ARMED: begin
          if (triggered) begin
            state_q <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          cnt_q <= cnt_d;
          if (rle_en_q) begin
            if (flush_hit_d) begin
              state_q <= S_FLUSH;
              flush_q <= 1'b1;
`ifdef RLE_SEQ_TIMEOUT_EN
              tmo_q   <= '0;
`endif
            end
          end else if (cnt_d == read_count_q) begin
            state_q      <= S_DONE;
            rle_enable_q <= 1'b0;
            done_q       <= 1'b1;
          end
        end

        S_FLUSH: begin
          cnt_q <= cnt_d;
          if (rle_flushed) begin
            state_q      <= S_DONE;
            flush_q      <= 1'b0;
            rle_enable_q <= 1'b0;
            done_q       <= 1'b1;
          end
`ifdef RLE_SEQ_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q         <= S_DONE;
            flush_q         <= 1'b0;
            rle_enable_q    <= 1'b0;
            done_q          <= 1'b1;
            flush_timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end

        S_DONE: begin
          if (arm) begin
            state_q      <= S_ARMED;
            cnt_q        <= '0;
            rle_enable_q <= rle_en_q;
            done_q       <= 1'b0;
            cfg_error_q  <= 1'b0;
`ifdef RLE_SEQ_TIMEOUT_EN
            flush_timeout_q <= 1'b0;
`endif
          end
        end

        default: begin
          state_q      <= S_IDLE;
          rle_enable_q <= 1'b0;
          flush_q      <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign rle_enable      = rle_enable_q;
  assign rle_mode        = rle_mode_q;
  assign rle_data_mask   = data_mask_q;
  assign rle_repeat_mode = repeat_q;
  assign rle_flush       = flush_q;
  assign capture_done    = done_q;
  assign cfg_error       = cfg_error_q;

endmodule
`default_nettype wire
